// File: rtl/led_seq_if.sv
// Control and configuration bundle for the LED pattern sequencer.
// The master drives run control and table writes; the sequencer is the slave.
interface led_seq_if #(
    parameter int LED_W = 8,
    parameter int STEPS = 4,
    parameter int DUR_W = 16
);
    localparam int AW = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic             en;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [AW-1:0]    last_step;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [LED_W-1:0] cfg_pat;
    logic [DUR_W-1:0] cfg_dur;

    modport master (
        output en, start, stop, mode, last_step,
        output cfg_we, cfg_addr, cfg_pat, cfg_dur
    );

    modport slave (
        input en, start, stop, mode, last_step,
        input cfg_we, cfg_addr, cfg_pat, cfg_dur
    );
endinterface

// File: rtl/led_seq.sv
// Programmable LED pattern sequencer: steps through a pattern/duration table
// in loop, one-shot or ping-pong order, with pause, stop and live table updates.
module led_seq #(
    parameter int               LED_W    = 8,
    parameter int               STEPS    = 4,
    parameter int               DUR_W    = 16,
    parameter logic [LED_W-1:0] IDLE_PAT = {LED_W{1'b1}},
    localparam int              AW       = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    led_seq_if.slave         bus,
    output logic [LED_W-1:0] led_o,
    output logic [AW-1:0]    step_o,
    output logic             busy,
    output logic             step_tick,
    output logic             done
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [DUR_W-1:0] r_cnt;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic [AW-1:0]    r_last;
    logic [AW-1:0]    r_step;
    logic [LED_W-1:0] r_led;
    logic             r_busy;
    logic             r_tick;
    logic             r_done;
    logic [LED_W-1:0] r_pat [STEPS];
    logic [DUR_W-1:0] r_dur [STEPS];

    logic          w_addr_ok;
    logic          w_at_last;
    logic          w_expire;
    logic [AW-1:0] w_nstep;
    logic          w_ndir;
    logic          w_finish;

    function automatic logic [AW-1:0] clamp_last(input logic [AW-1:0] v);
        if (32'(v) > 32'(STEPS - 1)) return AW'(STEPS - 1);
        return v;
    endfunction

    assign w_addr_ok = 32'(bus.cfg_addr) < 32'(STEPS);
    assign w_at_last = (r_step == r_last);
    // Live duration: a rewrite below the running count forces the advance.
    assign w_expire  = (r_cnt >= r_dur[r_step]);

    always_comb begin
        w_nstep  = r_step;
        w_ndir   = r_dir;
        w_finish = 1'b0;
        case (r_mode)
            2'd1: begin
                if (w_at_last) w_finish = 1'b1;
                else           w_nstep  = r_step + 1'b1;
            end
            2'd2: begin
                if (r_last == '0) begin
                    w_nstep = '0;
                end else if (r_dir) begin
                    if (w_at_last) begin
                        w_nstep = r_step - 1'b1;
                        w_ndir  = 1'b0;
                    end else begin
                        w_nstep = r_step + 1'b1;
                    end
                end else begin
                    if (r_step == '0) begin
                        w_nstep = AW'(1);
                        w_ndir  = 1'b1;
                    end else begin
                        w_nstep = r_step - 1'b1;
                    end
                end
            end
            default: w_nstep = w_at_last ? '0 : r_step + 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        r_tick <= 1'b0;
        r_done <= 1'b0;
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b1;
            r_mode  <= '0;
            r_last  <= '0;
            r_step  <= '0;
            r_led   <= IDLE_PAT;
            r_busy  <= 1'b0;
            for (int i = 0; i < STEPS; i++) begin
                r_pat[i] <= '0;
                r_dur[i] <= '0;
            end
        end else begin
            if (bus.cfg_we && w_addr_ok) begin
                r_pat[bus.cfg_addr] <= bus.cfg_pat;
                r_dur[bus.cfg_addr] <= bus.cfg_dur;
            end
            if (bus.stop) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_dir   <= 1'b1;
                r_step  <= '0;
                r_led   <= IDLE_PAT;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state <= S_RUN;
                            r_cnt   <= '0;
                            r_dir   <= 1'b1;
                            r_mode  <= bus.mode;
                            r_last  <= clamp_last(bus.last_step);
                            r_step  <= '0;
                            r_led   <= r_pat[0];
                            r_busy  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (bus.en) begin
                            if (w_expire) begin
                                r_cnt  <= '0;
                                r_tick <= 1'b1;
                                if (w_finish) begin
                                    r_state <= S_IDLE;
                                    r_led   <= IDLE_PAT;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_step <= w_nstep;
                                    r_dir  <= w_ndir;
                                    r_led  <= r_pat[w_nstep];
                                end
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign led_o     = r_led;
    assign step_o    = r_step;
    assign busy      = r_busy;
    assign step_tick = r_tick;
    assign done      = r_done;
endmodule

// File: tb/tb_led_seq.sv
// Directed bench for led_seq: vector table for loop/stop/one-shot runs,
// hand-written sequences for ping-pong, pause, live rewrites and clamping.
module tb_led_seq;
    logic clk;
    logic rst;

    led_seq_if #(.LED_W(8), .STEPS(4), .DUR_W(16)) bus ();
    led_seq_if #(.LED_W(8), .STEPS(3), .DUR_W(16)) bus3 ();

    logic [7:0] led_o, led3;
    logic [1:0] step_o, step3;
    logic       busy, step_tick, done;
    logic       busy3, tick3, done3;

    led_seq #(.LED_W(8), .STEPS(4), .DUR_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .led_o(led_o), .step_o(step_o), .busy(busy),
        .step_tick(step_tick), .done(done)
    );

    led_seq #(.LED_W(8), .STEPS(3), .DUR_W(16)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .led_o(led3), .step_o(step3), .busy(busy3),
        .step_tick(tick3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic       en, start, stop;
        logic [1:0] mode, ls;
        logic [7:0] led;
        logic [1:0] step;
        logic       cs, busy, tick, done;
    } vec_t;

    vec_t v [27];

    function automatic vec_t mk(input int e, input int s, input int p, input int m,
                                input int l, input int led, input int st, input int cs,
                                input int b, input int t, input int d);
        vec_t r;
        r.en = 1'(e);  r.start = 1'(s);  r.stop = 1'(p);
        r.mode = 2'(m); r.ls = 2'(l);
        r.led = 8'(led); r.step = 2'(st); r.cs = 1'(cs);
        r.busy = 1'(b); r.tick = 1'(t); r.done = 1'(d);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int led, input int st,
                           input int b, input int t, input int d);
        chk({nm, ".led"},  32'(led_o),     32'(led));
        chk({nm, ".step"}, 32'(step_o),    32'(st));
        chk({nm, ".busy"}, 32'(busy),      32'(b));
        chk({nm, ".tick"}, 32'(step_tick), 32'(t));
        chk({nm, ".done"}, 32'(done),      32'(d));
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input int p, input int d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'(a);
        bus.cfg_pat  = 8'(p);
        bus.cfg_dur  = 16'(d);
        clk_step();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic start_seq(input int m, input int l);
        bus.mode      = 2'(m);
        bus.last_step = 2'(l);
        bus.start     = 1'b1;
        clk_step();
        bus.start     = 1'b0;
    endtask

    task automatic stop_seq(input string nm);
        bus.stop = 1'b1;
        clk_step();
        bus.stop = 1'b0;
        chk({nm, ".led"},  32'(led_o), 32'hFF);
        chk({nm, ".busy"}, 32'(busy),  32'd0);
        chk({nm, ".done"}, 32'(done),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pats [4];
        int         pp   [8];
        int         s3   [4];
        pats = '{8'h03, 8'h3C, 8'hC0, 8'hFF};
        pp   = '{0, 1, 2, 3, 2, 1, 0, 1};
        s3   = '{1, 2, 0, 1};

        // loop run over {03,3C,C0,FF}/{2,0,3,1}, stop, start+stop, one-shot run
        v[0]  = mk(1,1,0,0,3, 'h03,0,1, 1,0,0);
        v[1]  = mk(1,0,0,0,3, 'h03,0,1, 1,0,0);
        v[2]  = mk(1,0,0,0,3, 'h03,0,1, 1,0,0);
        v[3]  = mk(1,0,0,0,3, 'h3C,1,1, 1,1,0);
        v[4]  = mk(1,0,0,0,3, 'hC0,2,1, 1,1,0);
        v[5]  = mk(1,1,0,1,0, 'hC0,2,1, 1,0,0);
        v[6]  = mk(1,0,0,0,3, 'hC0,2,1, 1,0,0);
        v[7]  = mk(1,0,0,0,3, 'hC0,2,1, 1,0,0);
        v[8]  = mk(1,0,0,0,3, 'hFF,3,1, 1,1,0);
        v[9]  = mk(1,0,0,0,3, 'hFF,3,1, 1,0,0);
        v[10] = mk(1,0,0,0,3, 'h03,0,1, 1,1,0);
        v[11] = mk(1,0,1,0,3, 'hFF,0,0, 0,0,0);
        v[12] = mk(1,1,1,0,3, 'hFF,0,0, 0,0,0);
        v[13] = mk(1,0,0,0,3, 'hFF,0,0, 0,0,0);
        v[14] = mk(1,1,0,1,3, 'h03,0,1, 1,0,0);
        v[15] = mk(1,0,0,1,3, 'h03,0,1, 1,0,0);
        v[16] = mk(1,0,0,1,3, 'h03,0,1, 1,0,0);
        v[17] = mk(1,0,0,1,3, 'h3C,1,1, 1,1,0);
        v[18] = mk(1,0,0,1,3, 'hC0,2,1, 1,1,0);
        v[19] = mk(1,0,0,1,3, 'hC0,2,1, 1,0,0);
        v[20] = mk(1,0,0,1,3, 'hC0,2,1, 1,0,0);
        v[21] = mk(1,0,0,1,3, 'hC0,2,1, 1,0,0);
        v[22] = mk(1,0,0,1,3, 'hFF,3,1, 1,1,0);
        v[23] = mk(1,0,0,1,3, 'hFF,3,1, 1,0,0);
        v[24] = mk(1,0,0,1,3, 'hFF,3,1, 0,1,1);
        v[25] = mk(1,0,0,1,3, 'hFF,3,1, 0,0,0);
        v[26] = mk(1,0,0,1,3, 'hFF,3,1, 0,0,0);

        rst = 1'b1;
        bus.en = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
        bus.mode = '0; bus.last_step = '0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_pat = '0; bus.cfg_dur = '0;
        bus3.en = 1'b1; bus3.start = 1'b0; bus3.stop = 1'b0;
        bus3.mode = '0; bus3.last_step = '0;
        bus3.cfg_we = 1'b0; bus3.cfg_addr = '0; bus3.cfg_pat = '0; bus3.cfg_dur = '0;
        clk_step();
        clk_step();
        chk_all("reset", 'hFF, 0, 0, 0, 0);
        chk("reset3.led", 32'(led3), 32'hFF);
        rst = 1'b0;

        // Reset table is pat=0/dur=0: one-shot of step 0 shows 00 then completes.
        start_seq(1, 0);
        chk_all("zero_tab_e1", 'h00, 0, 1, 0, 0);
        clk_step();
        chk_all("zero_tab_e2", 'hFF, 0, 0, 1, 1);

        cfg_write(0, 'h03, 2);
        cfg_write(1, 'h3C, 0);
        cfg_write(2, 'hC0, 3);
        cfg_write(3, 'hFF, 1);
        chk_all("idle_after_cfg", 'hFF, 0, 0, 0, 0);

        for (int i = 0; i < 27; i++) begin
            bus.en = v[i].en; bus.start = v[i].start; bus.stop = v[i].stop;
            bus.mode = v[i].mode; bus.last_step = v[i].ls;
            clk_step();
            chk($sformatf("vec%0d.led", i),  32'(led_o),     32'(v[i].led));
            if (v[i].cs)
                chk($sformatf("vec%0d.step", i), 32'(step_o), 32'(v[i].step));
            chk($sformatf("vec%0d.busy", i), 32'(busy),      32'(v[i].busy));
            chk($sformatf("vec%0d.tick", i), 32'(step_tick), 32'(v[i].tick));
            chk($sformatf("vec%0d.done", i), 32'(done),      32'(v[i].done));
        end
        bus.start = 1'b0; bus.stop = 1'b0; bus.en = 1'b1;

        // Ping-pong with all durations 0.
        for (int a = 0; a < 4; a++) cfg_write(a, int'(pats[a]), 0);
        start_seq(2, 3);
        chk_all("pp0", 'h03, 0, 1, 0, 0);
        for (int k = 1; k < 8; k++) begin
            clk_step();
            chk_all($sformatf("pp%0d", k), int'(pats[pp[k]]), pp[k], 1, 1, 0);
        end
        stop_seq("pp_stop");

        // Pause for 5 cycles in step 1 (dur 3).
        cfg_write(1, 'h3C, 3);
        start_seq(0, 3);
        chk_all("pause_e1", 'h03, 0, 1, 0, 0);
        clk_step();
        chk_all("pause_e2", 'h3C, 1, 1, 1, 0);
        clk_step();
        chk_all("pause_e3", 'h3C, 1, 1, 0, 0);
        bus.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            clk_step();
            chk_all($sformatf("paused%0d", k), 'h3C, 1, 1, 0, 0);
        end
        bus.en = 1'b1;
        clk_step();
        chk_all("resume1", 'h3C, 1, 1, 0, 0);
        clk_step();
        chk_all("resume2", 'h3C, 1, 1, 0, 0);
        clk_step();
        chk_all("resume3", 'hC0, 2, 1, 1, 0);
        stop_seq("midrun_stop");

        // Shrinking the running step's duration below cnt forces the advance.
        start_seq(0, 3);
        clk_step();
        clk_step();
        chk_all("rew_e3", 'h3C, 1, 1, 0, 0);
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_pat = 8'h3C; bus.cfg_dur = 16'd0;
        clk_step();
        bus.cfg_we = 1'b0;
        chk_all("rew_e4", 'h3C, 1, 1, 0, 0);
        clk_step();
        chk_all("rew_e5", 'hC0, 2, 1, 1, 0);
        stop_seq("rew_stop");

        // last_step=0 loop with dur 0 ticks every cycle.
        start_seq(0, 0);
        chk_all("ls0_e1", 'h03, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            clk_step();
            chk_all($sformatf("ls0_loop%0d", k), 'h03, 0, 1, 1, 0);
        end
        stop_seq("ls0_stop");

        // One-shot with last_step=0, dur[0]=1 completes after 2 cycles.
        cfg_write(0, 'h03, 1);
        start_seq(1, 0);
        chk_all("os0_e1", 'h03, 0, 1, 0, 0);
        clk_step();
        chk_all("os0_e2", 'h03, 0, 1, 0, 0);
        clk_step();
        chk_all("os0_e3", 'hFF, 0, 0, 1, 1);
        clk_step();
        chk_all("os0_e4", 'hFF, 0, 0, 0, 0);

        // 3-entry instance: write at index 3 is dropped and last_step 3 clamps to 2.
        bus3.cfg_we = 1'b1; bus3.cfg_addr = 2'd3; bus3.cfg_pat = 8'hAA; bus3.cfg_dur = 16'd5;
        clk_step();
        bus3.cfg_we = 1'b0;
        bus3.mode = 2'd0; bus3.last_step = 2'd3; bus3.start = 1'b1;
        clk_step();
        bus3.start = 1'b0;
        chk("clamp_e1.step", 32'(step3), 32'd0);
        chk("clamp_e1.busy", 32'(busy3), 32'd1);
        for (int k = 0; k < 4; k++) begin
            clk_step();
            chk($sformatf("clamp%0d.step", k), 32'(step3), 32'(s3[k]));
            chk($sformatf("clamp%0d.led", k),  32'(led3),  32'h00);
            chk($sformatf("clamp%0d.tick", k), 32'(tick3), 32'd1);
        end
        bus3.stop = 1'b1;
        clk_step();
        bus3.stop = 1'b0;
        chk("clamp_stop.led", 32'(led3), 32'hFF);

        // Reset mid-run aborts without done and clears the table.
        start_seq(0, 3);
        clk_step();
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        chk_all("rst_midrun", 'hFF, 0, 0, 0, 0);
        start_seq(0, 3);
        chk_all("rst_tab_e1", 'h00, 0, 1, 0, 0);
        clk_step();
        chk_all("rst_tab_e2", 'h00, 1, 1, 1, 0);
        stop_seq("final_stop");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/led_seq.md
Name: led_seq

Overview:
- Parametrised LED pattern sequencer; next generation of the board-level LED test driver.
- Replaces the fixed 16-bit free-running count and hard-coded pattern thresholds with a programmable pattern/duration table.
- Supports LED_W outputs, STEPS table entries, start/stop control, pause, and loop, one-shot and ping-pong modes.
- Drives board LED pins directly from the top level; the table is written by a simple config port from a CPU or test FSM.

Parameters:
- LED_W, 8, number of LED outputs.
- STEPS, 4, pattern table depth (>=1); AW = max(1, $clog2(STEPS)).
- DUR_W, 16, width of per-step duration field.
- IDLE_PAT, {LED_W{1'b1}}, led_o value in reset/idle.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low = pause (counter, step and outputs frozen).
- start  in  1  begin a sequence from idle (level sampled each cycle).
- stop  in  1  abort the sequence, return to idle.
- mode  in  2  0 = loop, 1 = one-shot, 2 = ping-pong, 3 = treated as loop; sampled on accepted start.
- last_step  in  AW  index of the final step used; sampled on accepted start; clamped to STEPS-1.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  AW  table index; writes with cfg_addr >= STEPS are ignored.
- cfg_pat  in  LED_W  pattern to write.
- cfg_dur  in  DUR_W  duration to write; the step is held cfg_dur+1 cycles.
- led_o  out  LED_W  registered LED drive.
- step_o  out  AW  current step index (registered).
- busy  out  1  high while sequencing (RUN).
- step_tick  out  1  one-cycle pulse on every step advance.
- done  out  1  one-cycle pulse on one-shot completion.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; led_o=IDLE_PAT, step_o=0, busy=0, step_tick=0, done=0, cnt=0, dir=up. Table entries reset to pat=0, dur=0. Reset mid-run aborts immediately, with no done pulse.
- States:
  - IDLE: led_o=IDLE_PAT.
  - RUN.
  - Pause is not a separate state; it is RUN with en=0.
- IDLE -> RUN: start=1 and stop=0. Next cycle: busy=1, step_o=0, led_o=pat[0], cnt=0, dir=up, mode/last_step latched. Start is accepted regardless of en.
- start while busy: ignored.
- stop=1, any state (lower priority only than rst): next cycle IDLE; led_o=IDLE_PAT; busy=0; no done. If stop and start are both high in the same cycle, stop wins.
- RUN with en=1, each cycle:
  - If cnt >= dur[step_o] (live table value): advance, cnt<=0, step_tick=1.
  - Otherwise cnt<=cnt+1.
  - The >= comparison guarantees progress if dur is rewritten below cnt.
- Advance rules (new step s'; led_o<=pat[s'] on the same edge):
  - Loop: s' = (step==last_step) ? 0 : step+1.
  - One-shot: at last_step, go to IDLE instead; led_o=IDLE_PAT, busy=0, done=1 for one cycle, step_o held at last_step; step_tick also pulses. Otherwise step+1.
  - Ping-pong: sequence 0,1,..,L,L-1,..,0,1..; endpoints are not repeated; dir flips on reaching L or 0.
  - last_step=0, any mode: step stays 0; step_tick pulses every dur[0]+1 cycles. One-shot with last_step=0 completes after dur[0]+1 cycles.
- RUN with en=0: cnt, step_o, led_o, dir frozen; step_tick=0. Resume continues the count exactly.
- Latency:
  - Step k is visible on led_o for exactly dur[k]+1 enabled cycles.
  - First pattern appears 1 cycle after start.
- Table writes:
  - Accepted in any state; effective the next cycle.
  - A pattern write to the current step does not change led_o until that step is re-entered.
  - A duration write to the current step affects the running comparison immediately.
- Counter: DUR_W bits; cannot overflow because cnt <= dur.

Test Plan:
- Reset then idle: rst 1 cycle -> led_o=8'hFF, busy=0, step_o=0, done=0; table reads pat=0, dur=0.
- Loop: pats {03,3C,C0,FF}, durs {2,0,3,1}, last_step=3, mode=0, start -> led_o 03 x3, 3C x1, C0 x4, FF x2, then 03 again; step_tick at each change.
- One-shot: same table, mode=1 -> after 10 cycles done pulses once, busy falls, led_o=FF, step_o=3; further cycles no tick.
- Ping-pong: durs all 0, last_step=3, mode=2 -> step_o 0,1,2,3,2,1,0,1 on consecutive cycles.
- Pause/stop: en low for 5 cycles mid-step 1 of dur 3 -> step_o and led_o frozen, step completes 4 enabled cycles total. Start+stop together -> stays IDLE. stop mid-run -> led_o=FF next cycle, no done.
- Edge cases: last_step=0 loop with dur 0 -> step_tick every cycle, led_o=pat[0]. Write dur[cur]=0 while cnt=2 -> advance next cycle. cfg_addr>=STEPS write -> table unchanged.
